// File: rtl/pi_pkg.sv
// Shared definitions for the pi column permutation family (forward and inverse).
// Matrix element (i,j) lives at bits [MAT_W-1-BYTE_W*byte_idx(i,j) -: BYTE_W].
package pi_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int BYTE_W = 8;
  localparam int MAT_W  = ROWS * COLS * BYTE_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Row-major position of element (i,j); also the serial byte number.
  function automatic int byte_idx(input int i, input int j);
    return COLS * i + j;
  endfunction

endpackage

// File: rtl/pi_inv.sv
// Combinational inverse of the cyclical column permutation pi:
// restored{i,j} = permuted{(i-j) mod 4, j}, i.e. column j moves back down by j rows.
module pi_inv
  import pi_pkg::*;
(
  input  logic [MAT_W-1:0] permuted,
  output logic [MAT_W-1:0] restored
);

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int SRC_ROW = (i - j + ROWS) % ROWS;
      localparam int DST_LSB = MAT_W - BYTE_W * (byte_idx(i, j) + 1);
      localparam int SRC_LSB = MAT_W - BYTE_W * (byte_idx(SRC_ROW, j) + 1);

      assign restored[DST_LSB +: BYTE_W] = permuted[SRC_LSB +: BYTE_W];
    end
  end

endmodule

// File: rtl/pi_inv_serializer.sv
// Unpermutes a 4x4 byte matrix with pi_inv and streams it out row-major, one
// byte per accepted cycle; the next matrix can load on byte 15's handshake.
module pi_inv_serializer #(
  parameter int ROWS   = 4,
  parameter int BYTE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWS*ROWS*BYTE_W-1:0] in_matrix,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W-1:0]           out_byte,
  output logic                        out_last
);
  import pi_pkg::*;

  localparam int          MW       = ROWS * ROWS * BYTE_W;
  localparam logic [3:0]  LAST_IDX = 4'(ROWS * ROWS - 1);

  state_t         state;
  logic [3:0]     idx;
  logic [MW-1:0]  hold;
  logic [MW-1:0]  restored;
  logic           at_last;
  logic           fire_in;
  logic           fire_out;

  pi_inv u_pi_inv (
    .permuted (in_matrix),
    .restored (restored)
  );

  assign at_last   = (idx == LAST_IDX);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && at_last;
  assign out_byte  = hold[MW - BYTE_W * (int'(idx) + 1) +: BYTE_W];
  assign fire_out  = out_valid && out_ready;

  // Combinational out_ready -> in_ready path gives back-to-back matrices with no bubble.
  assign in_ready  = (state == IDLE) || (fire_out && out_last);
  assign fire_in   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else if (fire_in) begin
      hold  <= restored;
      idx   <= '0;
      state <= SEND;
    end else if (fire_out) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pi_inv_serializer.sv
// Self-checking bench for pi_inv_serializer: table vectors, backpressure,
// back-to-back, reset mid-stream and a forward-pi round trip with random traffic.
module tb_pi_inv_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_matrix = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_byte;
  logic         out_last;

  pi_inv_serializer #(.ROWS(4), .BYTE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_matrix (in_matrix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] in_m;
    logic [127:0] exp_m;
  } vec_t;

  vec_t         vecs[4];
  int           compared = 0;
  int           mismatched = 0;
  logic [7:0]   sb[$];
  logic [127:0] pend_mat[$];
  logic [127:0] pend_exp[$];
  logic         stall_prev = 1'b0;
  logic [7:0]   stall_byte;
  logic         stall_last;
  int           last_count;
  int           valid_count;

  function automatic logic [7:0] get_byte(input logic [127:0] m, input int i, input int j);
    return m[127 - 8*(4*i + j) -: 8];
  endfunction

  // Encrypt-side pi: column j moves up by j rows.
  function automatic logic [127:0] fwd_pi(input logic [127:0] a);
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[127 - 8*(4*i + j) -: 8] = get_byte(a, (i + j) % 4, j);
    return r;
  endfunction

  function automatic logic [127:0] inv_pi(input logic [127:0] b);
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[127 - 8*(4*i + j) -: 8] = get_byte(b, (i - j + 4) % 4, j);
    return r;
  endfunction

  function automatic logic [127:0] rand_mat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just before posedge, then advance the model.
  task automatic apply_stimulus(input logic iv, input logic [127:0] mat, input logic [127:0] expm,
                                input logic ordy, output logic accepted);
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    in_valid  = iv;
    in_matrix = iv ? mat : rand_mat();
    out_ready = ordy;
    #4;
    exp_valid = (sb.size() != 0);
    exp_ready = !exp_valid || (ordy && sb.size() == 1);
    check_output("out_valid", 128'(out_valid), 128'(exp_valid));
    check_output("in_ready", 128'(in_ready), 128'(exp_ready));
    if (exp_valid) begin
      check_output("out_byte", 128'(out_byte), 128'(sb[0]));
      check_output("out_last", 128'(out_last), 128'(sb.size() == 1));
    end
    if (stall_prev && out_valid) begin
      check_output("stall_byte", 128'(out_byte), 128'(stall_byte));
      check_output("stall_last", 128'(out_last), 128'(stall_last));
    end
    stall_prev = out_valid && !ordy;
    stall_byte = out_byte;
    stall_last = out_last;
    if (out_valid) valid_count++;
    if (out_valid && out_last && ordy) last_count++;
    accepted = iv && exp_ready;
    if (exp_valid && ordy) void'(sb.pop_front());
    if (accepted)
      for (int k = 0; k < 16; k++) sb.push_back(expm[127 - 8*k -: 8]);
    @(posedge clk);
  endtask

  task automatic run_stream(input int ready_pct, input int valid_pct, input int budget);
    logic acc;
    logic iv;
    logic ordy;
    int   n = 0;
    while ((pend_mat.size() != 0 || sb.size() != 0) && n < budget) begin
      iv   = (pend_mat.size() != 0) && ($urandom_range(99) < valid_pct);
      ordy = ($urandom_range(99) < ready_pct);
      if (iv) apply_stimulus(1'b1, pend_mat[0], pend_exp[0], ordy, acc);
      else    apply_stimulus(1'b0, '0, '0, ordy, acc);
      if (acc) begin
        void'(pend_mat.pop_front());
        void'(pend_exp.pop_front());
      end
      n++;
    end
    check_output("stream_drained", 128'(pend_mat.size() + sb.size()), 128'(0));
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", 128'(out_valid), 128'(0));
    check_output("rst_out_byte", 128'(out_byte), 128'(0));
    check_output("rst_out_last", 128'(out_last), 128'(0));
    check_output("rst_in_ready", 128'(in_ready), 128'(1));
    sb.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    logic [127:0] a;

    vecs[0] = '{128'h01060B10_050A0F04_090E0308_0D02070C, 128'h01020304_05060708_090A0B0C_0D0E0F10};
    vecs[1] = '{128'h0055AAFF_4499EE33_88DD2277_CC1166BB, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    vecs[2] = '{128'h11223344_22334411_33441122_44112233, 128'h11111111_22222222_33333333_44444444};
    vecs[3] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};

    repeat (3) @(negedge clk);
    check_output("init_out_valid", 128'(out_valid), 128'(0));
    check_output("init_out_byte", 128'(out_byte), 128'(0));
    check_output("init_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    $display("[TB] idle cycles");
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, '0, '0, 1'($urandom_range(1)), acc);

    $display("[TB] table vectors, out_ready=1");
    for (int v = 0; v < 4; v++) begin
      pend_mat.push_back(vecs[v].in_m);
      pend_exp.push_back(vecs[v].exp_m);
      run_stream(100, 100, 100);
      apply_stimulus(1'b0, '0, '0, 1'b1, acc);
    end

    $display("[TB] backpressure on known vector");
    pend_mat.push_back(vecs[0].in_m);
    pend_exp.push_back(vecs[0].exp_m);
    run_stream(50, 100, 400);

    $display("[TB] back-to-back matrices");
    for (int k = 0; k < 2; k++) begin
      a = rand_mat();
      pend_mat.push_back(a);
      pend_exp.push_back(inv_pi(a));
    end
    last_count  = 0;
    valid_count = 0;
    run_stream(100, 100, 100);
    check_output("b2b_last_pulses", 128'(last_count), 128'(2));
    check_output("b2b_valid_cycles", 128'(valid_count), 128'(32));

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b1, vecs[1].in_m, vecs[1].exp_m, 1'b1, acc);
    check_output("rms_accept", 128'(acc), 128'(1));
    for (int k = 0; k < 7; k++) apply_stimulus(1'b0, '0, '0, 1'b1, acc);
    reset_mid_cycle();
    for (int k = 0; k < 2; k++) apply_stimulus(1'b0, '0, '0, 1'b1, acc);
    pend_mat.push_back(vecs[0].in_m);
    pend_exp.push_back(vecs[0].exp_m);
    run_stream(100, 100, 100);

    $display("[TB] round trip through forward pi, random traffic");
    for (int k = 0; k < 1000; k++) begin
      a = rand_mat();
      pend_mat.push_back(fwd_pi(a));
      pend_exp.push_back(a);
    end
    run_stream(75, 80, 40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
